// File: rtl/shared_pkg.sv
// Shared types and frame constants for the SPI master sequencer.
package shared_pkg;
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {IDLE, MODE, SHIFT, WAIT_RD, RECV, GAP} spi_mstate_e;

    localparam int MODE_BITS  = 1;
    localparam int FRAME_BITS = 10;
    localparam int RX_BITS    = 8;
endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load TX shifter (MSB first) and serial-in RX shifter for one SPI frame.
module spi_shift_reg
    import shared_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  tx_shift,
    input  logic                  rx_shift,
    input  logic                  rx_in,
    output logic [1:0]            tx_top,
    output logic [RX_BITS-1:0]    rx_next
);
    logic [FRAME_BITS-1:0] tx;
    logic [RX_BITS-1:0]    rx;

    always_ff @(posedge clk) begin
        if (clear) begin
            tx <= '0;
            rx <= '0;
        end else begin
            if (load)
                tx <= load_word;
            else if (tx_shift)
                tx <= {tx[FRAME_BITS-2:0], 1'b0};
            if (rx_shift)
                rx <= rx_next;
        end
    end

    // Top two bits: [1] is the bit for MODE->SHIFT, [0] the bit after each shift.
    assign tx_top  = tx[FRAME_BITS-1 -: 2];
    assign rx_next = {rx[RX_BITS-2:0], rx_in};
endmodule

// File: rtl/spi_master_seq.sv
// SPI master sequencer: one request -> one frame (mode bit, 10-bit word, optional 8-bit read).
module spi_master_seq
    import shared_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int RD_LAT     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_data,
    input  logic       abort,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy
);
    localparam int MAX_A = (GAP_CYCLES > RD_LAT) ? GAP_CYCLES : RD_LAT;
    localparam int MAX_V = (MAX_A > RX_BITS) ? MAX_A : RX_BITS;
    localparam int CW    = $clog2(MAX_V + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'((RD_LAT == 0) ? 0 : RD_LAT - 1);
    localparam logic [CW-1:0] RX_LAST  = CW'(RX_BITS - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

    spi_mstate_e state, state_n;
    spi_cmd_e    cmd_q;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic        load, tx_shift, rx_shift, rsp_fire, ss_n_n, mosi_n;
    logic [1:0]  tx_top;
    logic [RX_BITS-1:0] rx_next;

    spi_shift_reg u_shift (
        .clk      (clk),
        .clear    (rst),
        .load     (load),
        .load_word({req_cmd, req_data}),
        .tx_shift (tx_shift),
        .rx_shift (rx_shift),
        .rx_in    (MISO),
        .tx_top   (tx_top),
        .rx_next  (rx_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_q     <= WR_ADDR;
            bit_cnt   <= '0;
            cnt       <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            cnt       <= cnt_n;
            SS_n      <= ss_n_n;
            MOSI      <= mosi_n;
            rsp_valid <= rsp_fire;
            if (load)
                cmd_q <= spi_cmd_e'(req_cmd);
            if (rsp_fire)
                rsp_data <= rx_next;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        cnt_n     = cnt;
        load      = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                state_n   = MODE;
                load      = 1'b1;
                bit_cnt_n = '0;
            end
            MODE: begin
                state_n   = SHIFT;
                bit_cnt_n = '0;
            end
            SHIFT: begin
                tx_shift  = 1'b1;
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (cmd_q != RD_DATA)  state_n = GAP;
                    else if (RD_LAT == 0)  state_n = RECV;
                    else                   state_n = WAIT_RD;
                end
            end
            WAIT_RD: begin
                cnt_n = cnt + 1'b1;
                if (cnt == RD_LAST) begin
                    state_n = RECV;
                    cnt_n   = '0;
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                cnt_n    = cnt + 1'b1;
                if (cnt == RX_LAST) begin
                    state_n  = GAP;
                    cnt_n    = '0;
                    rsp_fire = 1'b1;
                end
            end
            GAP: begin
                cnt_n = cnt + 1'b1;
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides any in-frame transition and suppresses the reply.
        if (abort && state != IDLE && state != GAP) begin
            state_n  = GAP;
            cnt_n    = '0;
            rsp_fire = 1'b0;
        end

        ss_n_n = !(state_n == MODE || state_n == SHIFT || state_n == WAIT_RD || state_n == RECV);
        if (state_n == MODE)
            mosi_n = req_cmd[1];
        else if (state_n == SHIFT)
            mosi_n = (state == MODE) ? tx_top[1] : tx_top[0];
        else
            mosi_n = 1'b0;
    end

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && !rst;
endmodule
